// File: rtl/inv_sub_bytes_pkg.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_pkg
// Shared AES definitions for the decryption datapath:
//   aes_state_t / aes_byte_t  - 128-bit state and byte types
//   isb_state_e               - inv_sub_bytes FSM encoding
//   INV_SBOX                  - 256-entry inverse S-box
//   inv_shift_rows()          - InvShiftRows permutation (byte 0 = [127:120])
// ---------------------------------------------------------------------------
package inv_sub_bytes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } isb_state_e;

  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Output byte 4c+r takes input byte 4((c-r) mod 4)+r, i.e. input bytes
  // 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3 in output order.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    return {s[127:120], s[23:16],   s[47:40],   s[71:64],
            s[95:88],   s[119:112], s[15:8],    s[39:32],
            s[63:56],   s[87:80],   s[111:104], s[7:0],
            s[31:24],   s[55:48],   s[79:72],   s[103:96]};
  endfunction

endpackage

// File: rtl/inv_sub_bytes_sbox.sv
// ---------------------------------------------------------------------------
// inv_sbox
// Combinational AES inverse S-box lookup.
//   i_byte : byte to substitute
//   o_byte : InvSBox(i_byte)
// ---------------------------------------------------------------------------
module inv_sbox
  import inv_sub_bytes_pkg::*;
(
  input  aes_byte_t i_byte,
  output aes_byte_t o_byte
);

  always_comb begin
    o_byte = INV_SBOX[i_byte];
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes
// Sequential AES-128 InvSubBytes stage. Accepts a 128-bit state over a
// valid/ready handshake, substitutes BYTES_PER_CYCLE bytes per clock
// (MSB-first chunks) and presents the result under its own handshake.
//   BYTES_PER_CYCLE : 1, 2, 4, 8 or 16 bytes substituted per clock
//   clk, n_rst      : clock, asynchronous active-low reset
//   i_clear         : synchronous abort to IDLE (highest priority)
//   i_data/i_valid/o_ready : input state handshake
//   o_data/o_valid/i_ready : output state handshake
// Optional build macro INV_SUB_BYTES_FUSED_SHIFT_EN: the state register
// loads InvShiftRows(i_data) on accept instead of i_data.
// ---------------------------------------------------------------------------
module inv_sub_bytes
  import inv_sub_bytes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_clear,
  input  aes_state_t i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output aes_state_t o_data,
  output logic       o_valid,
  input  logic       i_ready
);

  localparam int unsigned NCHUNK = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
    $error("inv_sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  isb_state_e    r_fsm;
  logic [CW-1:0] r_cnt;
  aes_state_t    r_state;
  logic          r_valid;
  logic          r_idle;

  aes_byte_t     w_bytes   [16];
  logic [3:0]    w_idx     [BYTES_PER_CYCLE];
  aes_byte_t     w_sb_in   [BYTES_PER_CYCLE];
  aes_byte_t     w_sb_out  [BYTES_PER_CYCLE];
  aes_state_t    w_next_state;
  aes_state_t    w_load;

  for (genvar k = 0; k < 16; k++) begin : g_bytes
    assign w_bytes[k] = r_state[127-8*k -: 8];
    // Byte k belongs to chunk k/BPC and uses lane k%BPC of the S-box bank.
    assign w_next_state[127-8*k -: 8] =
      (CW'(k / BYTES_PER_CYCLE) == r_cnt) ? w_sb_out[k % BYTES_PER_CYCLE] : w_bytes[k];
  end

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    assign w_idx[j]   = 4'(r_cnt * BYTES_PER_CYCLE + j);
    assign w_sb_in[j] = w_bytes[w_idx[j]];
    inv_sbox u_sbox (
      .i_byte (w_sb_in[j]),
      .o_byte (w_sb_out[j])
    );
  end

`ifdef INV_SUB_BYTES_FUSED_SHIFT_EN
  assign w_load = inv_shift_rows(i_data);
`else
  assign w_load = i_data;
`endif

  // o_ready is the only output with a combinational input dependency,
  // and only through i_ready while a result is being presented.
  assign o_ready = r_idle | (r_valid & i_ready);
  assign o_valid = r_valid;
  assign o_data  = r_state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_fsm   <= ST_IDLE;
      r_cnt   <= '0;
      r_state <= '0;
      r_valid <= 1'b0;
      r_idle  <= 1'b1;
    end else if (i_clear) begin
      r_fsm   <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      unique case (r_fsm)
        ST_IDLE: begin
          if (i_valid) begin
            r_state <= w_load;
            r_cnt   <= '0;
            r_fsm   <= ST_BUSY;
            r_idle  <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_state <= w_next_state;
          if (r_cnt == LAST_CHUNK) begin
            r_cnt   <= '0;
            r_fsm   <= ST_DONE;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            if (i_valid) begin
              r_state <= w_load;
              r_cnt   <= '0;
              r_fsm   <= ST_BUSY;
            end else begin
              r_fsm  <= ST_IDLE;
              r_idle <= 1'b1;
            end
          end
        end
        default: begin
          r_fsm   <= ST_IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes.sv
// ---------------------------------------------------------------------------
// tb_inv_sub_bytes
// Self-checking bench for inv_sub_bytes: default-BPC instance with a
// scoreboard, plus BPC=1/2/8/16 instances for the latency sweep.
// Expected data comes from a GF(2^8) inverse S-box model and constants.
// ---------------------------------------------------------------------------
module tb_inv_sub_bytes;
  import inv_sub_bytes_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       i_clear;
  aes_state_t i_data;
  logic       i_valid;
  logic       i_ready;
  logic       o_ready;
  aes_state_t o_data;
  logic       o_valid;

  logic       s_ready [4];
  aes_state_t s_data  [4];
  logic       s_valid [4];

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  aes_state_t  sb_q[$];
  int unsigned out_cyc[$];
  aes_state_t  last_out;
  aes_state_t  m_exp;

  typedef struct {
    aes_state_t din;
    aes_state_t exp;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes dut (
    .clk(clk), .n_rst(n_rst), .i_clear(i_clear), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready)
  );
  inv_sub_bytes #(.BYTES_PER_CYCLE(1)) dut_b1 (
    .clk(clk), .n_rst(n_rst), .i_clear(i_clear), .i_data(i_data), .i_valid(i_valid),
    .o_ready(s_ready[0]), .o_data(s_data[0]), .o_valid(s_valid[0]), .i_ready(i_ready)
  );
  inv_sub_bytes #(.BYTES_PER_CYCLE(2)) dut_b2 (
    .clk(clk), .n_rst(n_rst), .i_clear(i_clear), .i_data(i_data), .i_valid(i_valid),
    .o_ready(s_ready[1]), .o_data(s_data[1]), .o_valid(s_valid[1]), .i_ready(i_ready)
  );
  inv_sub_bytes #(.BYTES_PER_CYCLE(8)) dut_b8 (
    .clk(clk), .n_rst(n_rst), .i_clear(i_clear), .i_data(i_data), .i_valid(i_valid),
    .o_ready(s_ready[2]), .o_data(s_data[2]), .o_valid(s_valid[2]), .i_ready(i_ready)
  );
  inv_sub_bytes #(.BYTES_PER_CYCLE(16)) dut_b16 (
    .clk(clk), .n_rst(n_rst), .i_clear(i_clear), .i_data(i_data), .i_valid(i_valid),
    .o_ready(s_ready[3]), .o_data(s_data[3]), .o_valid(s_valid[3]), .i_ready(i_ready)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_inv_sbox(input logic [7:0] s);
    logic [7:0] x;
    x = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic aes_state_t model_block(input aes_state_t d);
    aes_state_t t;
    aes_state_t r;
`ifdef INV_SUB_BYTES_FUSED_SHIFT_EN
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        t[127-8*(4*c+rr) -: 8] = d[127-8*(4*((c+4-rr)%4)+rr) -: 8];
`else
    t = d;
`endif
    for (int k = 0; k < 16; k++)
      r[127-8*k -: 8] = m_inv_sbox(t[127-8*k -: 8]);
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input aes_state_t act, input aes_state_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: each completed output handshake pops the scoreboard.
  always @(negedge clk) begin
    if (n_rst && o_valid && i_ready) begin
      out_cyc.push_back(cyc);
      last_out = o_data;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", o_data);
      end else begin
        m_exp = sb_q.pop_front();
        chk("out_data", o_data, m_exp);
      end
    end
  end

  // Drive one block and hold i_valid until the DUT accepts it.
  task automatic accept(input aes_state_t d, input aes_state_t e);
    int n = 0;
    i_data  = d;
    i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) chk_int("accept_timeout", 0, 1);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic no_valid_window(input string name);
    int seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_valid) seen = 1;
    end
    chk_int(name, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    int guard;
    int slat [4];
    aes_state_t sdat [4];
    aes_state_t seq_in;
    aes_state_t stream [3];
    int exp_lat [4];
    logic [31:0] exp_head;

    exp_lat = '{16, 8, 2, 1};
    seq_in  = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef INV_SUB_BYTES_FUSED_SHIFT_EN
    exp_head = 32'h52f3a338;
`else
    exp_head = 32'h52096ad5;
`endif
    vecs[0] = '{din: '0,              exp: {16{8'h52}}};
    vecs[1] = '{din: {16{8'h63}},     exp: '0};
    vecs[2] = '{din: seq_in,          exp: model_block(seq_in)};
    vecs[3] = '{din: {4{32'hdeadbeef}}, exp: model_block({4{32'hdeadbeef}})};
    vecs[4] = '{din: 128'hffeeddccbbaa99887766554433221100,
                exp: model_block(128'hffeeddccbbaa99887766554433221100)};

    n_rst = 1'b0; i_clear = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o_valid", 128'(o_valid), 128'(0));
    chk("reset_o_ready", 128'(o_ready), 128'(1));
    chk("reset_o_data", o_data, '0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors at default BPC.
    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].din, vecs[v].exp);
      wait_valid(lat);
      chk_int("latency_bpc4", lat, 4);
      @(posedge clk); #1;
      if (v == 2) chk("first_bytes", 128'(last_out[127:96]), 128'(exp_head));
    end

    // Backpressure: result held for 10 cycles with i_ready low.
    i_ready = 1'b0;
    accept({16{8'h63}}, '0);
    wait_valid(lat);
    chk_int("latency_hold", lat, 4);
    repeat (10) begin
      chk("hold_o_valid", 128'(o_valid), 128'(1));
      chk("hold_o_ready", 128'(o_ready), 128'(0));
      chk("hold_o_data", o_data, '0);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_o_valid", 128'(o_valid), 128'(0));
    chk("release_o_ready", 128'(o_ready), 128'(1));

    // Back-to-back stream of 3 blocks.
    stream[0] = 128'h0123456789abcdeffedcba9876543210;
    stream[1] = {4{$urandom}};
    stream[2] = {$urandom, $urandom, $urandom, $urandom};
    out_cyc.delete();
    k = 0; guard = 0;
    i_valid = 1'b1;
    i_data  = stream[0];
    while (k < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (o_ready) begin
        sb_q.push_back(model_block(stream[k]));
        @(posedge clk); #1;
        k++;
        if (k < 3) i_data = stream[k];
        else i_valid = 1'b0;
      end
    end
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk_int("stream_outputs", out_cyc.size(), 3);
    if (out_cyc.size() == 3) begin
      chk_int("stream_gap01", int'(out_cyc[1] - out_cyc[0]), 5);
      chk_int("stream_gap12", int'(out_cyc[2] - out_cyc[1]), 5);
    end

    // Clear at BUSY cycle 2 with i_valid high.
    accept(stream[0], model_block(stream[0]));
    @(posedge clk); #1;
    i_clear = 1'b1; i_valid = 1'b1; i_data = stream[1];
    @(posedge clk); #1;
    i_clear = 1'b0; i_valid = 1'b0;
    chk("clear_busy_o_ready", 128'(o_ready), 128'(1));
    chk("clear_busy_o_valid", 128'(o_valid), 128'(0));
    sb_q.delete();
    no_valid_window("clear_busy_no_valid");

    // Clear in IDLE beats a simultaneous accept.
    @(posedge clk); #1;
    i_clear = 1'b1; i_valid = 1'b1; i_data = stream[2];
    @(posedge clk); #1;
    i_clear = 1'b0; i_valid = 1'b0;
    chk("clear_idle_o_ready", 128'(o_ready), 128'(1));
    no_valid_window("clear_idle_no_accept");
    @(posedge clk); #1;
    accept(stream[2], model_block(stream[2]));
    wait_valid(lat);
    chk_int("latency_after_clear", lat, 4);
    @(posedge clk); #1;

    // Asynchronous reset during BUSY.
    accept(stream[1], model_block(stream[1]));
    @(posedge clk); #1;
    n_rst = 1'b0;
    #1;
    chk("rst_busy_o_valid", 128'(o_valid), 128'(0));
    chk("rst_busy_o_ready", 128'(o_ready), 128'(1));
    chk("rst_busy_o_data", o_data, '0);
    sb_q.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Asynchronous reset during DONE.
    i_ready = 1'b0;
    @(posedge clk); #1;
    accept(stream[2], model_block(stream[2]));
    wait_valid(lat);
    chk_int("latency_pre_rst", lat, 4);
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_done_o_valid", 128'(o_valid), 128'(0));
    chk("rst_done_o_ready", 128'(o_ready), 128'(1));
    chk("rst_done_o_data", o_data, '0);
    sb_q.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;
    i_ready = 1'b1;
    @(posedge clk); #1;

    // Latency sweep across BPC variants, all accepting the same zero block.
    i_data = '0;
    i_valid = 1'b1;
    sb_q.push_back({16{8'h52}});
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      slat[s] = 0;
      sdat[s] = '1;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      for (int s = 0; s < 4; s++)
        if (s_valid[s] && slat[s] == 0) begin
          slat[s] = n;
          sdat[s] = s_data[s];
        end
    end
    for (int s = 0; s < 4; s++) begin
      chk_int($sformatf("sweep_latency_%0d", s), slat[s], exp_lat[s]);
      chk($sformatf("sweep_data_%0d", s), sdat[s], {16{8'h52}});
    end

    chk_int("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
